// File: rtl/traffic_pkg.sv
// Definitions shared by the side-road vehicle detector and the traffic-light controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    LOW_STABLE  = 2'd0,
    CHK_HIGH    = 2'd1,
    HIGH_STABLE = 2'd2,
    CHK_LOW     = 2'd3
  } deb_state_e;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  typedef enum logic [2:0] {
    S001  = 3'd0,
    S010  = 3'd1,
    S100  = 3'd2,
    SS001 = 3'd3,
    SS010 = 3'd4,
    SS100 = 3'd5
  } ctrl_state_e;

  // Bits needed to hold values 0..maxval (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned maxval);
    return (maxval < 2) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/side_vehicle_detector_sensor_debounce.sv
// Loop-sensor conditioning: two-flop synchronizer followed by a debounce FSM.
module sensor_debounce
  import traffic_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic Dreset,
  input  logic raw_in,
  output logic filt_out
);

  localparam int unsigned     DW    = cnt_width(DEB_CYCLES);
  localparam logic [DW-1:0]   DLAST = DW'(DEB_CYCLES - 1);

  logic            s1;
  logic            s2;
  deb_state_e      state;
  logic [DW-1:0]   dcnt;

  always_ff @(posedge clk) begin
    if (Dreset) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      state    <= LOW_STABLE;
      dcnt     <= '0;
      filt_out <= 1'b0;
    end else begin
      s1 <= raw_in;
      s2 <= s1;
      case (state)
        LOW_STABLE: begin
          if (s2) begin
            // A single-sample debounce commits on the first opposite sample.
            if (DEB_CYCLES == 1) begin
              state    <= HIGH_STABLE;
              filt_out <= 1'b1;
              dcnt     <= '0;
            end else begin
              state <= CHK_HIGH;
              dcnt  <= DW'(1);
            end
          end
        end
        CHK_HIGH: begin
          if (!s2) begin
            state <= LOW_STABLE;
            dcnt  <= '0;
          end else if (dcnt == DLAST) begin
            state    <= HIGH_STABLE;
            filt_out <= 1'b1;
            dcnt     <= '0;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        HIGH_STABLE: begin
          if (!s2) begin
            if (DEB_CYCLES == 1) begin
              state    <= LOW_STABLE;
              filt_out <= 1'b0;
              dcnt     <= '0;
            end else begin
              state <= CHK_LOW;
              dcnt  <= DW'(1);
            end
          end
        end
        CHK_LOW: begin
          if (s2) begin
            state <= HIGH_STABLE;
            dcnt  <= '0;
          end else if (dcnt == DLAST) begin
            state    <= LOW_STABLE;
            filt_out <= 1'b0;
            dcnt     <= '0;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: begin
          state <= LOW_STABLE;
          dcnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/side_vehicle_detector.sv
// Side-road request generator: counts debounced loop arrivals, retires them during
// side green, and raises a starvation alarm when waiting vehicles see no green.
module side_vehicle_detector
  import traffic_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = 4,
  parameter int unsigned PASS_CYCLES = 8,
  parameter int unsigned MAX_Q       = 7,
  parameter int unsigned CNT_W       = 3,
  parameter int unsigned MAX_WAIT    = 32
) (
  input  logic             clk,
  input  logic             Dreset,
  input  logic             raw_loop,
  input  logic             side_green,
  output logic             Dss,
  output logic [CNT_W-1:0] qcount,
  output logic             q_ovf,
  output logic             wait_alarm
);

  localparam int unsigned      PW    = cnt_width(PASS_CYCLES);
  localparam int unsigned      WW    = cnt_width(MAX_WAIT);
  localparam logic [PW-1:0]    PLAST = PW'(PASS_CYCLES - 1);
  localparam logic [WW-1:0]    WLAST = WW'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0] QMAX  = CNT_W'(MAX_Q);

  logic             filt;
  logic             filt_d;
  logic             arr;
  logic             dep;
  logic             ovf_set;
  logic [CNT_W-1:0] q_next;
  logic [PW-1:0]    ptmr;
  logic [WW-1:0]    wtmr;

  sensor_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .Dreset   (Dreset),
    .raw_in   (raw_loop),
    .filt_out (filt)
  );

  // Arrival and departure on the same edge cancel, so neither moves the queue.
  always_comb begin
    arr     = filt & ~filt_d;
    dep     = side_green & (ptmr == PLAST);
    q_next  = qcount;
    ovf_set = 1'b0;
    if (arr && !dep) begin
      if (qcount == QMAX) begin
        ovf_set = 1'b1;
      end else begin
        q_next = qcount + 1'b1;
      end
    end else if (dep && !arr && (qcount != '0)) begin
      q_next = qcount - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (Dreset) begin
      filt_d     <= 1'b0;
      ptmr       <= '0;
      wtmr       <= '0;
      qcount     <= '0;
      Dss        <= 1'b0;
      q_ovf      <= 1'b0;
      wait_alarm <= 1'b0;
    end else begin
      filt_d <= filt;
      ptmr   <= (side_green && !dep) ? ptmr + 1'b1 : '0;
      qcount <= q_next;
      Dss    <= (q_next != '0);
      if (ovf_set) begin
        q_ovf <= 1'b1;
      end
      // The wait timer parks at its terminal value while the alarm is held.
      if (side_green || (qcount == '0)) begin
        wtmr       <= '0;
        wait_alarm <= 1'b0;
      end else if (wtmr == WLAST) begin
        wait_alarm <= 1'b1;
      end else begin
        wtmr <= wtmr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_side_vehicle_detector.sv
// Randomized and directed bench for side_vehicle_detector against a behavioural model.
module tb_side_vehicle_detector;

  localparam int unsigned DEB  = 4;
  localparam int unsigned PASS = 8;
  localparam int unsigned MAXQ = 7;
  localparam int unsigned MAXW = 32;

  logic       clk        = 1'b0;
  logic       Dreset     = 1'b1;
  logic       raw_loop   = 1'b0;
  logic       side_green = 1'b0;
  logic       Dss;
  logic [2:0] qcount;
  logic       q_ovf;
  logic       wait_alarm;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  side_vehicle_detector #(
    .DEB_CYCLES  (DEB),
    .PASS_CYCLES (PASS),
    .MAX_Q       (MAXQ),
    .CNT_W       (3),
    .MAX_WAIT    (MAXW)
  ) dut (
    .clk        (clk),
    .Dreset     (Dreset),
    .raw_loop   (raw_loop),
    .side_green (side_green),
    .Dss        (Dss),
    .qcount     (qcount),
    .q_ovf      (q_ovf),
    .wait_alarm (wait_alarm)
  );

  always #5 clk = ~clk;

  // Model: raw level seen two samples late; the filtered level flips after DEB
  // consecutive opposite samples; each rise of it is one vehicle.
  bit m_d0, m_d1, m_filt, m_filt_d, m_ovf, m_arr, m_dep;
  int m_run, m_q, m_q_old, m_green, m_starve;

  always @(posedge clk) begin
    if (Dreset) begin
      m_d0 = 0; m_d1 = 0; m_filt = 0; m_filt_d = 0; m_ovf = 0;
      m_run = 0; m_q = 0; m_green = 0; m_starve = 0;
    end else begin
      m_arr = m_filt && !m_filt_d;
      if (side_green) begin
        m_green++;
        m_dep = (m_green % PASS) == 0;
      end else begin
        m_green = 0;
        m_dep = 0;
      end
      m_q_old = m_q;
      if (m_arr && !m_dep) begin
        if (m_q < MAXQ) m_q++;
        else m_ovf = 1;
      end else if (m_dep && !m_arr && m_q > 0) begin
        m_q--;
      end
      if (side_green || m_q_old == 0) m_starve = 0;
      else if (m_starve < MAXW) m_starve++;
      m_filt_d = m_filt;
      if (m_d1 != m_filt) begin
        m_run++;
        if (m_run == DEB) begin
          m_filt = !m_filt;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_d1 = m_d0;
      m_d0 = raw_loop;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_qcount", 32'(qcount), 32'(m_q));
      check("model_Dss", 32'(Dss), 32'(m_q != 0));
      check("model_q_ovf", 32'(q_ovf), 32'(m_ovf));
      check("model_wait_alarm", 32'(wait_alarm), 32'(m_starve >= MAXW));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_q(input string name, input int q, input bit ovf);
    check({name, "_qcount"}, 32'(qcount), 32'(q));
    check({name, "_model_q"}, 32'(m_q), 32'(q));
    check({name, "_Dss"}, 32'(Dss), 32'(q != 0));
    check({name, "_q_ovf"}, 32'(q_ovf), 32'(ovf));
  endtask

  task automatic arrive();
    raw_loop = 1'b1;
    cyc(10);
    raw_loop = 1'b0;
    cyc(10);
  endtask

  task automatic pulse_reset();
    Dreset = 1'b1;
    cyc(1);
    Dreset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cyc(2);
    Dreset = 1'b0;
    chk_en = 1'b1;
    expect_q("reset", 0, 0);
    check("reset_alarm", 32'(wait_alarm), 0);
    cyc(20);
    expect_q("idle", 0, 0);

    raw_loop = 1'b1; cyc(3);
    raw_loop = 1'b0; cyc(10);
    expect_q("glitch", 0, 0);
    raw_loop = 1'b1; cyc(6);
    expect_q("latency_edge6", 0, 0);
    cyc(1);
    expect_q("latency_edge7", 1, 0);
    cyc(3);
    raw_loop = 1'b0; cyc(10);
    pulse_reset();
    expect_q("reset2", 0, 0);

    for (int k = 1; k <= 7; k++) begin
      arrive();
      expect_q("fill", k, 0);
    end
    side_green = 1'b1; cyc(1);
    raw_loop = 1'b1; cyc(7);
    side_green = 1'b0;
    expect_q("arr_dep_same_edge", 7, 0);
    cyc(3);
    raw_loop = 1'b0; cyc(10);
    arrive();
    expect_q("overflow8", 7, 1);
    arrive();
    expect_q("overflow9", 7, 1);

    pulse_reset();
    arrive(); arrive();
    expect_q("dep_start", 2, 0);
    side_green = 1'b1; cyc(7);
    expect_q("dep_edge7", 2, 0);
    cyc(1);
    expect_q("dep_edge8", 1, 0);
    cyc(7);
    expect_q("dep_edge15", 1, 0);
    cyc(1);
    expect_q("dep_edge16", 0, 0);
    side_green = 1'b0; cyc(2);
    arrive();
    expect_q("partial_start", 1, 0);
    side_green = 1'b1; cyc(5);
    side_green = 1'b0; cyc(3);
    expect_q("partial_pass", 1, 0);
    side_green = 1'b1; cyc(7);
    expect_q("partial_discarded", 1, 0);
    side_green = 1'b0;

    cyc(31);
    check("starve_31", 32'(wait_alarm), 0);
    cyc(1);
    check("starve_32", 32'(wait_alarm), 1);
    side_green = 1'b1; cyc(1);
    side_green = 1'b0;
    check("starve_clear", 32'(wait_alarm), 0);
    expect_q("starve_q", 1, 0);

    raw_loop = 1'b1; cyc(4);
    Dreset = 1'b1; cyc(1);
    Dreset = 1'b0;
    expect_q("mid_debounce_reset", 0, 0);
    check("mid_reset_alarm", 32'(wait_alarm), 0);
    cyc(6);
    expect_q("restart_edge6", 0, 0);
    cyc(1);
    expect_q("restart_edge7", 1, 0);
    raw_loop = 1'b0; cyc(10);

    for (int n = 0; n < 500; n++) begin
      int len;
      raw_loop   = 1'($urandom_range(0, 1));
      side_green = ($urandom_range(0, 2) == 0);
      len = $urandom_range(1, 14);
      for (int c = 0; c < len; c++) begin
        Dreset = ($urandom_range(0, 299) == 0);
        cyc(1);
      end
      Dreset = 1'b0;
    end
    cyc(2);
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
